// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full flags and occupancy for the async FIFO.
// Flags are computed from the next pointer, so they move on the edge that accepts a push.
module fifo_wptr_full #(
  parameter int unsigned ADDR_SIZE    = 3,
  parameter int unsigned AFULL_THRESH = 1
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 woverflow
);

  localparam int unsigned        DEPTH   = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AFULL_W = (ADDR_SIZE+1)'(AFULL_THRESH);

  logic [ADDR_SIZE:0] wbin_q, wbin_d;
  logic [ADDR_SIZE:0] wptr_q, wgray_d;
  logic [ADDR_SIZE:0] wlevel_q, wlevel_d;
  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] free_d;
  logic               wfull_q, wfull_d;
  logic               wafull_q, wafull_d;
  logic               wovf_q, wovf_d;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i <= ADDR_SIZE; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  always_comb begin
    wen      = winc & ~wfull_q;
    wbin_d   = wbin_q + {{ADDR_SIZE{1'b0}}, wen};
    wgray_d  = (wbin_d >> 1) ^ wbin_d;
    wlevel_d = wbin_d - rbin;
    free_d   = DEPTH_W - wlevel_d;
    wfull_d  = (wgray_d == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]});
    wafull_d = (free_d <= AFULL_W);
    wovf_d   = wovf_q | (winc & wfull_q);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDR_SIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: directed vector table, wrap sequence, then randomized
// pushes/read releases compared against a counter-based occupancy model.
module tb_fifo_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       winc;
  logic [3:0] wq2_rptr;
  logic       wen;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       woverflow;

  int checks   = 0;
  int failures = 0;

  fifo_wptr_full #(.ADDR_SIZE(3), .AFULL_THRESH(1)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic       rst;
    logic       inc;
    int         rd;
    logic       chkpre;
    logic       e_wen;
    logic [2:0] e_waddr;
    logic [3:0] e_wptr;
    logic       e_full;
    logic       e_afull;
    logic [3:0] e_level;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  // Model state: total pushes accepted / entries released since reset.
  int   m_wr;
  int   m_rd;
  logic m_full;
  logic m_afull;
  logic m_ovf;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic rst, input logic inc, input int rd, input logic chkpre,
                      input logic e_wen, input int e_waddr, input int e_wptr,
                      input logic e_full, input logic e_afull, input int e_level,
                      input logic e_ovf);
    vec_t v;
    v.rst = rst; v.inc = inc; v.rd = rd; v.chkpre = chkpre;
    v.e_wen = e_wen; v.e_waddr = 3'(e_waddr); v.e_wptr = 4'(e_wptr);
    v.e_full = e_full; v.e_afull = e_afull; v.e_level = 4'(e_level); v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic inc, input int rd);
    @(negedge wclk);
    wrst     = rst;
    winc     = inc;
    wq2_rptr = gray(rd);
    #1;
  endtask

  // One model-checked cycle; new_rd is the released-entry count visible this cycle.
  task automatic mstep(input logic rst, input logic inc, input int new_rd);
    logic e_wen;
    int   lvl;
    drive(rst, inc, new_rd);
    e_wen = inc && !m_full;
    chk("m_wen", 32'(wen), 32'(e_wen));
    chk("m_waddr", 32'(waddr), 32'(m_wr % 8));
    @(posedge wclk);
    #1;
    if (rst) begin
      m_wr = 0; m_rd = 0; m_full = 0; m_afull = 0; m_ovf = 0;
      lvl = 0;
    end else begin
      m_ovf  = m_ovf || (inc && m_full);
      m_wr   = m_wr + (e_wen ? 1 : 0);
      m_rd   = new_rd;
      lvl    = m_wr - m_rd;
      m_full = (lvl == 8);
      m_afull = ((8 - lvl) <= 1);
    end
    chk("m_wptr", 32'(wptr), 32'(gray(m_wr)));
    chk("m_wfull", 32'(wfull), 32'(m_full));
    chk("m_afull", 32'(walmost_full), 32'(m_afull));
    chk("m_wlevel", 32'(wlevel), 32'(lvl));
    chk("m_ovf", 32'(woverflow), 32'(m_ovf));
  endtask

  initial begin
    wrst = 1'b1; winc = 1'b0; wq2_rptr = '0;

    // rst inc rd chkpre | wen waddr wptr full afull level ovf
    addv(1, 0, 0, 0,  0, 0, 'h0, 0, 0, 0, 0);
    addv(0, 1, 0, 1,  1, 0, 'h1, 0, 0, 1, 0);
    addv(0, 1, 0, 1,  1, 1, 'h3, 0, 0, 2, 0);
    addv(0, 1, 0, 1,  1, 2, 'h2, 0, 0, 3, 0);
    addv(0, 1, 0, 1,  1, 3, 'h6, 0, 0, 4, 0);
    addv(0, 1, 0, 1,  1, 4, 'h7, 0, 0, 5, 0);
    addv(0, 1, 0, 1,  1, 5, 'h5, 0, 0, 6, 0);
    addv(0, 1, 0, 1,  1, 6, 'h4, 0, 1, 7, 0);
    addv(0, 1, 0, 1,  1, 7, 'hC, 1, 1, 8, 0);
    addv(0, 1, 0, 1,  0, 0, 'hC, 1, 1, 8, 1);
    addv(0, 1, 0, 1,  0, 0, 'hC, 1, 1, 8, 1);
    addv(0, 1, 0, 1,  0, 0, 'hC, 1, 1, 8, 1);
    addv(0, 0, 1, 1,  0, 0, 'hC, 0, 1, 7, 1);
    addv(0, 1, 1, 1,  1, 0, 'hD, 1, 1, 8, 1);
    addv(1, 1, 1, 1,  0, 1, 'h0, 0, 0, 0, 0);
    addv(0, 1, 0, 1,  1, 0, 'h1, 0, 0, 1, 0);
    addv(0, 1, 0, 1,  1, 1, 'h3, 0, 0, 2, 0);
    addv(0, 1, 0, 1,  1, 2, 'h2, 0, 0, 3, 0);
    addv(0, 1, 0, 1,  1, 3, 'h6, 0, 0, 4, 0);
    addv(0, 1, 0, 1,  1, 4, 'h7, 0, 0, 5, 0);
    addv(1, 1, 0, 1,  1, 5, 'h0, 0, 0, 0, 0);
    addv(0, 0, 0, 1,  0, 0, 'h0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].inc, vecs[i].rd);
      if (vecs[i].chkpre) begin
        chk($sformatf("v%0d_wen", i), 32'(wen), 32'(vecs[i].e_wen));
        chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(vecs[i].e_waddr));
      end
      @(posedge wclk);
      #1;
      chk($sformatf("v%0d_wptr", i), 32'(wptr), 32'(vecs[i].e_wptr));
      chk($sformatf("v%0d_wfull", i), 32'(wfull), 32'(vecs[i].e_full));
      chk($sformatf("v%0d_afull", i), 32'(walmost_full), 32'(vecs[i].e_afull));
      chk($sformatf("v%0d_wlevel", i), 32'(wlevel), 32'(vecs[i].e_level));
      chk($sformatf("v%0d_ovf", i), 32'(woverflow), 32'(vecs[i].e_ovf));
    end

    // Wrap: read pointer trails two entries behind across the pointer wrap.
    m_wr = 0; m_rd = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    mstep(1, 0, 0);
    mstep(0, 1, 0);
    mstep(0, 1, 0);
    begin
      logic saw8, saw80;
      saw8 = 0; saw80 = 0;
      for (int k = 0; k < 20; k++) begin
        mstep(0, 1, m_wr - 1);
        chk("wrap_level", 32'(wlevel), 32'd2);
        chk("wrap_full", 32'(wfull), 32'd0);
        if (saw8 && wptr == 4'h0) saw80 = 1;
        saw8 = (wptr == 4'h8);
      end
      chk("wrap_8_then_0", 32'(saw80), 32'd1);
    end

    // Randomized pushes, read releases and occasional resets.
    mstep(1, 0, 0);
    for (int n = 0; n < 600; n++) begin
      logic rst, inc;
      int   nrd;
      rst = ($urandom_range(0, 79) == 0);
      inc = ($urandom_range(0, 3) != 0);
      nrd = m_rd;
      if (!rst && $urandom_range(0, 2) == 0)
        nrd = m_rd + int'($urandom_range(0, 32'(m_wr - m_rd)));
      mstep(rst, inc, nrd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
